// File: rtl/interfaz_tx_pkg.sv
// -----------------------------------------------------------------------------
// interfaz_tx_pkg
// Shared definitions for the UART-ALU return path: FSM state encoding
// (IDLE/SEND/WAIT on 2 bits), the default frame width and a helper that
// sizes the byte counter.
// -----------------------------------------------------------------------------
package interfaz_tx_pkg;

    localparam int DBIT_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_WAIT = 2'b10
    } tx_state_e;

    // Counter width: clog2 of the byte count, never narrower than one bit.
    function automatic int cnt_width(input int nbytes);
        if (nbytes > 1) begin
            return $clog2(nbytes);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/interfaz_tx.sv
// -----------------------------------------------------------------------------
// interfaz_tx
// Captures the ALU result on i_valid, then feeds it LSB-byte first to the UART
// transmitter: one o_tx_start pulse per byte, waiting for i_tx_done between
// bytes. Results arriving while a transfer is in progress are discarded and
// flagged on o_drop.
//
// Ports
//   i_clk       system clock, rising edge
//   i_rst       asynchronous reset, active low
//   i_result    ALU result (DBIT*NBYTES), sampled when i_valid=1 in IDLE
//   i_valid     one-cycle pulse, i_result is valid
//   i_tx_done   one-cycle tick from UART TX, current frame finished
//   o_tx_start  one-cycle pulse, UART TX loads o_tx_data
//   o_tx_data   registered byte to transmit
//   o_busy      high while not IDLE
//   o_drop      one-cycle pulse, an i_valid was discarded while busy
// -----------------------------------------------------------------------------
module interfaz_tx
    import interfaz_tx_pkg::*;
#(
    parameter int DBIT   = DBIT_DEFAULT,
    parameter int NBYTES = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [DBIT*NBYTES-1:0]   i_result,
    input  logic                     i_valid,
    input  logic                     i_tx_done,
    output logic                     o_tx_start,
    output logic [DBIT-1:0]          o_tx_data,
    output logic                     o_busy,
    output logic                     o_drop
);

    localparam int CW = cnt_width(NBYTES);
    localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

    tx_state_e                  state_q,    state_d;
    logic [CW-1:0]              cnt_q,      cnt_d;
    logic [DBIT*NBYTES-1:0]     capture_q,  capture_d;
    logic                       tx_start_q, tx_start_d;
    logic [DBIT-1:0]            tx_data_q,  tx_data_d;
    logic                       busy_q,     busy_d;
    logic                       drop_q,     drop_d;

    // Next-state and next-data logic for the transmit FSMD.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture_d  = capture_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;

        case (state_q)
            ST_IDLE: begin
                // i_tx_done is deliberately ignored here.
                if (i_valid) begin
                    capture_d = i_result;
                    cnt_d     = '0;
                    state_d   = ST_SEND;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SEND: begin
                tx_data_d  = capture_q[int'(cnt_q) * DBIT +: DBIT];
                tx_start_d = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // A done tick coinciding with the start pulse is accepted:
                // the state is already WAIT in that cycle.
                if (i_tx_done) begin
                    if (cnt_q == LAST_BYTE) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q + CW'(1'b1);
                        state_d = ST_SEND;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A result offered while busy is not queued, only reported.
        if (i_valid && (state_q != ST_IDLE)) begin
            drop_d = 1'b1;
        end else begin
            drop_d = 1'b0;
        end

        // Busy is registered from the next state so it tracks state != IDLE.
        if (state_d != ST_IDLE) begin
            busy_d = 1'b1;
        end else begin
            busy_d = 1'b0;
        end
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            capture_q  <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            capture_q  <= capture_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
        end
    end

    assign o_tx_start = tx_start_q;
    assign o_tx_data  = tx_data_q;
    assign o_busy     = busy_q;
    assign o_drop     = drop_q;

endmodule

// File: tb/tb_interfaz_tx.sv
// -----------------------------------------------------------------------------
// tb_interfaz_tx
// Self-checking bench for interfaz_tx with two instances: u_dut1 (NBYTES=1)
// and u_dut2 (NBYTES=2). Inputs change and outputs are sampled on the falling
// edge. Expected bytes come from shifting the offered result; a monitor logs
// every start pulse and the log is compared with the expected byte stream.
// -----------------------------------------------------------------------------
module tb_interfaz_tx;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [7:0]  res1 = 8'h00;
    logic        val1 = 1'b0;
    logic        done1 = 1'b0;
    logic        start1, busy1, drop1;
    logic [7:0]  data1;

    logic [15:0] res2 = 16'h0000;
    logic        val2 = 1'b0;
    logic        done2 = 1'b0;
    logic        start2, busy2, drop2;
    logic [7:0]  data2;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp1[$];
    logic [7:0] exp2[$];
    logic [7:0] obs1[$];
    logic [7:0] obs2[$];

    always #5 clk = ~clk;

    interfaz_tx #(.DBIT(8), .NBYTES(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst_n), .i_result(res1), .i_valid(val1),
        .i_tx_done(done1), .o_tx_start(start1), .o_tx_data(data1),
        .o_busy(busy1), .o_drop(drop1)
    );

    interfaz_tx #(.DBIT(8), .NBYTES(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst_n), .i_result(res2), .i_valid(val2),
        .i_tx_done(done2), .o_tx_start(start2), .o_tx_data(data2),
        .o_busy(busy2), .o_drop(drop2)
    );

    // Log every byte handed to the transmitter.
    always @(negedge clk) begin
        if (start1) obs1.push_back(data1);
        if (start2) obs2.push_back(data2);
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input int w, input logic v, input logic [15:0] r, input logic d);
        if (w == 1) begin
            val1 = v; res1 = r[7:0]; done1 = d;
        end else begin
            val2 = v; res2 = r; done2 = d;
        end
    endtask

    function automatic logic [15:0] o_start(input int w);
        return (w == 1) ? {15'd0, start1} : {15'd0, start2};
    endfunction
    function automatic logic [15:0] o_busy(input int w);
        return (w == 1) ? {15'd0, busy1} : {15'd0, busy2};
    endfunction
    function automatic logic [15:0] o_drop(input int w);
        return (w == 1) ? {15'd0, drop1} : {15'd0, drop2};
    endfunction
    function automatic logic [15:0] o_data(input int w);
        return (w == 1) ? {8'd0, data1} : {8'd0, data2};
    endfunction

    // One complete transfer: valid at cycle c, start at c+2, then per byte a
    // done tick dly cycles after its start, next start two cycles after done.
    task automatic xfer(input int w, input logic [15:0] res, input int dly0,
                        input int dly1, input bit inj);
        int nb;
        int dl;
        logic [7:0] b;
        nb = (w == 1) ? 1 : 2;
        drive(w, 1'b1, res, 1'b0);
        step();
        drive(w, 1'b0, res, 1'b0);
        chk("busy_after_valid", o_busy(w), 16'd1);
        chk("no_start_c1", o_start(w), 16'd0);
        step();
        for (int k = 0; k < nb; k++) begin
            b = 8'((res >> (8 * k)) & 16'h00FF);
            chk("start_pulse", o_start(w), 16'd1);
            chk("start_data", o_data(w), {8'd0, b});
            if (w == 1) exp1.push_back(b); else exp2.push_back(b);
            dl = (k == 0) ? dly0 : dly1;
            if (inj && k == 0) begin
                if (dl < 2) dl = 2;
                drive(w, 1'b1, 16'h0077, 1'b0);
            end
            for (int j = 0; j < dl; j++) begin
                step();
                if (inj && k == 0 && j == 0) begin
                    drive(w, 1'b0, 16'h0077, 1'b0);
                    chk("drop_pulse", o_drop(w), 16'd1);
                end else begin
                    chk("drop_quiet", o_drop(w), 16'd0);
                end
                chk("wait_no_start", o_start(w), 16'd0);
                chk("wait_busy", o_busy(w), 16'd1);
                chk("wait_data_hold", o_data(w), {8'd0, b});
            end
            drive(w, 1'b0, 16'h0000, 1'b1);
            step();
            drive(w, 1'b0, 16'h0000, 1'b0);
            chk("after_done_no_start", o_start(w), 16'd0);
            if (k < nb - 1) begin
                chk("busy_between_bytes", o_busy(w), 16'd1);
                step();
            end else begin
                chk("idle_after_last", o_busy(w), 16'd0);
                chk("data_held_after", o_data(w), {8'd0, b});
            end
        end
    endtask

    initial begin
        logic [31:0] r;
        int d0;
        int d1;
        bit inj;

        // 1: reset held with inputs toggling
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_start1", o_start(1), 16'd0);
            chk("rst_start2", o_start(2), 16'd0);
            chk("rst_busy2", o_busy(2), 16'd0);
            chk("rst_data2", o_data(2), 16'd0);
            chk("rst_drop2", o_drop(2), 16'd0);
            drive(1, 1'($urandom_range(0, 1)), 16'h00A5, 1'($urandom_range(0, 1)));
            drive(2, 1'($urandom_range(0, 1)), 16'h1234, 1'($urandom_range(0, 1)));
        end
        drive(1, 1'b0, 16'h0000, 1'b0);
        drive(2, 1'b0, 16'h0000, 1'b0);
        rst_n = 1'b1;
        step();
        chk("post_rst_busy1", o_busy(1), 16'd0);
        chk("post_rst_data1", o_data(1), 16'd0);

        // 2: single byte, done 18 cycles after start
        xfer(1, 16'h00A5, 18, 0, 1'b0);
        step();
        chk("no_further_start1", o_start(1), 16'd0);

        // 3: two bytes, LSB first
        xfer(2, 16'h1234, 3, 5, 1'b0);

        // 4: valid during WAIT is dropped, then normal transfer
        xfer(2, 16'hABCD, 4, 2, 1'b1);
        xfer(2, 16'h9876, 0, 0, 1'b0);

        // 5: asynchronous reset while waiting after the first byte
        drive(2, 1'b1, 16'hBEEF, 1'b0);
        step();
        drive(2, 1'b0, 16'h0000, 1'b0);
        step();
        chk("abort_start", o_start(2), 16'd1);
        chk("abort_data", o_data(2), 16'h00EF);
        exp2.push_back(8'hEF);
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", o_busy(2), 16'd0);
        chk("async_data", o_data(2), 16'd0);
        chk("async_start", o_start(2), 16'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("idle_after_abort", o_busy(2), 16'd0);
        chk("no_start_after_abort", o_start(2), 16'd0);
        xfer(2, 16'h003C, 2, 1, 1'b0);

        // 6: done ticks in IDLE ignored, then back-to-back results
        for (int i = 0; i < 3; i++) begin
            drive(1, 1'b0, 16'h0000, 1'b1);
            step();
            chk("idle_done_busy", o_busy(1), 16'd0);
            chk("idle_done_start", o_start(1), 16'd0);
        end
        drive(1, 1'b0, 16'h0000, 1'b0);
        xfer(1, 16'h00C3, 1, 0, 1'b0);
        xfer(1, 16'h005A, 2, 0, 1'b0);

        // Randomized transfers on both instances
        for (int i = 0; i < 16; i++) begin
            r   = $urandom;
            d0  = $urandom_range(0, 4);
            d1  = $urandom_range(0, 4);
            inj = ($urandom_range(0, 3) == 0);
            xfer(2, r[15:0], d0, d1, inj);
            if ($urandom_range(0, 1) == 1) step();
        end
        for (int i = 0; i < 6; i++) begin
            r   = $urandom;
            d0  = $urandom_range(0, 3);
            inj = ($urandom_range(0, 2) == 0);
            xfer(1, r[15:0], d0, 0, inj);
        end
        step();
        step();

        // Byte stream scoreboard
        chk("count_bytes1", 16'(obs1.size()), 16'(exp1.size()));
        chk("count_bytes2", 16'(obs2.size()), 16'(exp2.size()));
        for (int i = 0; i < exp1.size() && i < obs1.size(); i++)
            chk("stream1", {8'd0, obs1[i]}, {8'd0, exp1[i]});
        for (int i = 0; i < exp2.size() && i < obs2.size(); i++)
            chk("stream2", {8'd0, obs2[i]}, {8'd0, exp2[i]});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
